// File: rtl/d8_text_arbiter_if.sv
// Bus bundle between the d8 CPU store path, the text scanner
// and the single-port text RAM, as seen by the arbiter.
interface d8_text_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_a;
    logic [7:0]  cpu_dw;
    logic        cpu_ack;
    logic [7:0]  cpu_dr;
    logic        cpu_rvalid;

    logic        vid_req;
    logic [11:0] vid_a;
    logic        vid_ack;
    logic [7:0]  vid_dr;
    logic        vid_rvalid;

    logic [11:0] mem_a;
    logic [7:0]  mem_dw;
    logic        mem_we;
    logic [7:0]  mem_dr;

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_dw,
        input  vid_req, vid_a,
        input  mem_dr,
        output cpu_ack, cpu_dr, cpu_rvalid,
        output vid_ack, vid_dr, vid_rvalid,
        output mem_a, mem_dw, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_dw,
        output vid_req, vid_a,
        output mem_dr,
        input  cpu_ack, cpu_dr, cpu_rvalid,
        input  vid_ack, vid_dr, vid_rvalid,
        input  mem_a, mem_dw, mem_we
    );
endinterface

// File: rtl/d8_text_arbiter.sv
// Text RAM arbiter: CPU fixed priority, video anti-starvation,
// registered memory command, 2-cycle in-order read return.
module d8_text_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    d8_text_arbiter_if.slave  bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] vid_wait;
    logic          vid_force;
    logic          cpu_go;
    logic          vid_go;
    logic          p0_v;
    logic          p0_vid;
    logic          p1_v;
    logic          p1_vid;

    // Video overrides the CPU only once it has waited MAX_WAIT edges.
    assign vid_force   = bus.vid_req && (vid_wait == WW'(MAX_WAIT));
    assign bus.cpu_ack = bus.cpu_req && !vid_force;
    assign bus.vid_ack = bus.vid_req && (vid_force || !bus.cpu_req);

    assign cpu_go = bus.cpu_req && bus.cpu_ack;
    assign vid_go = bus.vid_req && bus.vid_ack;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.mem_a  <= '0;
            bus.mem_dw <= '0;
            bus.mem_we <= 1'b0;
        end else begin
            bus.mem_we <= cpu_go && bus.cpu_we;
            if (cpu_go) begin
                bus.mem_a <= bus.cpu_a;
                if (bus.cpu_we)
                    bus.mem_dw <= bus.cpu_dw;
            end else if (vid_go) begin
                bus.mem_a <= bus.vid_a;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vid_wait <= '0;
        end else if (!bus.vid_req || vid_go) begin
            vid_wait <= '0;
        end else if (vid_wait != WW'(MAX_WAIT)) begin
            vid_wait <= vid_wait + WW'(1);
        end
    end

    // Stage 0 tracks the RAM address cycle, stage 1 the RAM data cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            p0_v   <= 1'b0;
            p0_vid <= 1'b0;
            p1_v   <= 1'b0;
            p1_vid <= 1'b0;
        end else begin
            p0_v   <= (cpu_go && !bus.cpu_we) || vid_go;
            p0_vid <= vid_go;
            p1_v   <= p0_v;
            p1_vid <= p0_vid;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.cpu_dr     <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_dr     <= '0;
            bus.vid_rvalid <= 1'b0;
        end else begin
            bus.cpu_rvalid <= p1_v && !p1_vid;
            bus.vid_rvalid <= p1_v && p1_vid;
            if (p1_v) begin
                if (p1_vid)
                    bus.vid_dr <= bus.mem_dr;
                else
                    bus.cpu_dr <= bus.mem_dr;
            end
        end
    end

endmodule
